// File: rtl/lms_step_sequencer.sv
// lms_step_sequencer
// Sequencer for a 2-tap LMS identification step. It accepts one (x, y) sample
// pair per handshake. A single signed 8x8 multiplier is shared across five
// phases: two prediction products, error formation, and two coefficient-update
// products. The block owns the coefficients and the one-sample delay line.
//
// Ports
//   clk, reset          : rising-edge clock, synchronous active-high reset
//   coef_load           : load a_init/b_init into the coefficients (IDLE only)
//   a_init, b_init      : signed Q1.6 initial coefficients
//   adapt_en            : update coefficients for this step (sampled at accept)
//   in_valid / in_ready : sample handshake (x_in, y_in)
//   out_valid/out_ready : result handshake; results hold while out_valid=1
//   y_hat, err          : prediction and prediction error of the last step
//   a_hat, b_hat        : current coefficients
module lms_step_sequencer #(
  parameter int FRAC     = 6,
  parameter int MU_SHIFT = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              coef_load,
  input  logic signed [7:0] a_init,
  input  logic signed [7:0] b_init,
  input  logic              adapt_en,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic signed [7:0] x_in,
  input  logic signed [7:0] y_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic signed [7:0] y_hat,
  output logic signed [7:0] err,
  output logic signed [7:0] a_hat,
  output logic signed [7:0] b_hat
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    MUL_AX = 3'd1,
    MUL_BY = 3'd2,
    ERR    = 3'd3,
    UPD_A  = 3'd4,
    UPD_B  = 3'd5,
    DONE   = 3'd6
  } state_t;

  state_t             state_r;
  logic signed [7:0]  x_last_r;
  logic signed [7:0]  y_last_r;
  logic signed [7:0]  x_lat_r;
  logic signed [7:0]  y_lat_r;
  logic               adapt_r;
  logic signed [15:0] p_ax_r;

  logic signed [7:0]  mul_a_s;
  logic signed [7:0]  mul_b_s;
  logic signed [15:0] prod_s;
  logic signed [15:0] prod_frac_s;
  logic signed [15:0] prod_upd_s;
  logic signed [15:0] y_sum_s;
  logic signed [15:0] err_diff_s;
  logic signed [15:0] a_sum_s;
  logic signed [15:0] b_sum_s;

  function automatic logic signed [15:0] sext16(input logic signed [7:0] v);
    sext16 = {{8{v[7]}}, v};
  endfunction

  // Clamp a wide intermediate to the signed 8-bit range.
  function automatic logic signed [7:0] sat8(input logic signed [15:0] v);
    if (v > 16'sd127) begin
      sat8 = 8'sd127;
    end else if (v < -16'sd128) begin
      sat8 = -8'sd128;
    end else begin
      sat8 = v[7:0];
    end
  endfunction

  assign in_ready = (state_r == IDLE) && !coef_load;

  // Operand mux for the single shared multiplier; idle (zero) outside the multiply phases.
  always_comb begin
    mul_a_s = 8'sd0;
    mul_b_s = 8'sd0;
    case (state_r)
      MUL_AX: begin mul_a_s = a_hat; mul_b_s = x_last_r; end
      MUL_BY: begin mul_a_s = b_hat; mul_b_s = y_last_r; end
      UPD_A:  begin mul_a_s = err;   mul_b_s = x_last_r; end
      UPD_B:  begin mul_a_s = err;   mul_b_s = y_last_r; end
      default: begin mul_a_s = 8'sd0; mul_b_s = 8'sd0; end
    endcase
  end

  // Product scaling and the adders feeding each phase. Every intermediate is
  // kept 16 bits wide so nothing can wrap before saturation.
  always_comb begin
    prod_s      = sext16(mul_a_s) * sext16(mul_b_s);
    prod_frac_s = prod_s >>> FRAC;
    prod_upd_s  = prod_s >>> (FRAC + MU_SHIFT);
    y_sum_s     = p_ax_r + prod_frac_s;
    err_diff_s  = sext16(y_lat_r) - sext16(y_hat);
    a_sum_s     = sext16(a_hat) + prod_upd_s;
    b_sum_s     = sext16(b_hat) + prod_upd_s;
  end

  // Step FSM with all datapath registers and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      out_valid <= 1'b0;
      y_hat     <= 8'sd0;
      err       <= 8'sd0;
      a_hat     <= 8'sd0;
      b_hat     <= 8'sd0;
      x_last_r  <= 8'sd0;
      y_last_r  <= 8'sd0;
      x_lat_r   <= 8'sd0;
      y_lat_r   <= 8'sd0;
      adapt_r   <= 1'b0;
      p_ax_r    <= 16'sd0;
    end else begin
      case (state_r)
        IDLE: begin
          // coef_load wins over a pending sample; in_ready is low meanwhile.
          if (coef_load) begin
            a_hat <= a_init;
            b_hat <= b_init;
          end else if (in_valid) begin
            x_lat_r <= x_in;
            y_lat_r <= y_in;
            adapt_r <= adapt_en;
            state_r <= MUL_AX;
          end
        end
        MUL_AX: begin
          p_ax_r  <= prod_frac_s;
          state_r <= MUL_BY;
        end
        MUL_BY: begin
          y_hat   <= sat8(y_sum_s);
          state_r <= ERR;
        end
        ERR: begin
          err <= sat8(err_diff_s);
          if (adapt_r) begin
            state_r <= UPD_A;
          end else begin
            x_last_r  <= x_lat_r;
            y_last_r  <= y_lat_r;
            out_valid <= 1'b1;
            state_r   <= DONE;
          end
        end
        UPD_A: begin
          a_hat   <= sat8(a_sum_s);
          state_r <= UPD_B;
        end
        UPD_B: begin
          // The delay line shifts only here, so this product still sees the old y_last.
          b_hat     <= sat8(b_sum_s);
          x_last_r  <= x_lat_r;
          y_last_r  <= y_lat_r;
          out_valid <= 1'b1;
          state_r   <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state_r   <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lms_step_sequencer.sv
// Directed testbench for lms_step_sequencer.
module tb_lms_step_sequencer;

  logic              clk;
  logic              reset;
  logic              coef_load;
  logic signed [7:0] a_init;
  logic signed [7:0] b_init;
  logic              adapt_en;
  logic              in_valid;
  logic              in_ready;
  logic signed [7:0] x_in;
  logic signed [7:0] y_in;
  logic              out_valid;
  logic              out_ready;
  logic signed [7:0] y_hat;
  logic signed [7:0] err;
  logic signed [7:0] a_hat;
  logic signed [7:0] b_hat;

  int tests_run;
  int tests_failed;

  lms_step_sequencer #(.FRAC(6), .MU_SHIFT(3)) dut (
    .clk(clk), .reset(reset), .coef_load(coef_load), .a_init(a_init), .b_init(b_init),
    .adapt_en(adapt_en), .in_valid(in_valid), .in_ready(in_ready), .x_in(x_in), .y_in(y_in),
    .out_valid(out_valid), .out_ready(out_ready), .y_hat(y_hat), .err(err),
    .a_hat(a_hat), .b_hat(b_hat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_coef(input logic signed [7:0] a, input logic signed [7:0] b);
    coef_load = 1'b1; a_init = a; b_init = b;
    tick();
    coef_load = 1'b0;
  endtask

  // Accept one sample and wait for out_valid; lat = edges after the accept edge.
  task automatic run_sample(input logic signed [7:0] x, input logic signed [7:0] y,
                            input logic adapt, output int lat, output int busy_bad);
    int w;
    w = 0;
    busy_bad = 0;
    while (!in_ready && w < 20) begin tick(); w++; end
    x_in = x; y_in = y; adapt_en = adapt; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (lat < 20) begin
      tick();
      lat++;
      if (in_ready !== 1'b0) busy_bad++;
      if (out_valid === 1'b1) break;
    end
    tests_run++;
    if (out_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL sample_timeout: out_valid=%b after %0d edges, want 1", out_valid, lat);
    end
  endtask

  task automatic ack();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
    tests_run++; if ({y_hat, err, a_hat, b_hat} !== 32'h0) begin tests_failed++; $display("FAIL rst_regs: got %0d %0d %0d %0d want 0 0 0 0", y_hat, err, a_hat, b_hat); end
  endtask

  task automatic test_basic_update();
    int lat, busy;
    load_coef(8'sd32, 8'sd0);
    tests_run++; if (a_hat !== 8'sd32 || b_hat !== 8'sd0) begin tests_failed++; $display("FAIL basic_load: got a=%0d b=%0d want 32 0", a_hat, b_hat); end
    run_sample(8'sd64, 8'sd0, 1'b0, lat, busy);
    tests_run++; if (y_hat !== 8'sd0 || err !== 8'sd0) begin tests_failed++; $display("FAIL basic_first: got y_hat=%0d err=%0d want 0 0", y_hat, err); end
    ack();
    run_sample(8'sd0, 8'sd40, 1'b1, lat, busy);
    tests_run++; if (lat !== 5) begin tests_failed++; $display("FAIL basic_latency: got %0d want 5", lat); end
    tests_run++; if (busy !== 0) begin tests_failed++; $display("FAIL basic_busy: in_ready high %0d times want 0", busy); end
    tests_run++; if (y_hat !== 8'sd32) begin tests_failed++; $display("FAIL basic_y_hat: got %0d want 32", y_hat); end
    tests_run++; if (err !== 8'sd8) begin tests_failed++; $display("FAIL basic_err: got %0d want 8", err); end
    tests_run++; if (a_hat !== 8'sd33) begin tests_failed++; $display("FAIL basic_a_hat: got %0d want 33", a_hat); end
    tests_run++; if (b_hat !== 8'sd0) begin tests_failed++; $display("FAIL basic_b_hat: got %0d want 0", b_hat); end
    ack();
  endtask

  task automatic test_saturation();
    int lat, busy;
    load_coef(8'sd127, 8'sd127);
    // x_last=0, y_last=40: y_hat = floor(127*40/64) = 79, err = 127-79 = 48
    run_sample(8'sd127, 8'sd127, 1'b0, lat, busy);
    tests_run++; if (y_hat !== 8'sd79 || err !== 8'sd48) begin tests_failed++; $display("FAIL sat_prime: got y_hat=%0d err=%0d want 79 48", y_hat, err); end
    ack();
    // 252 + 252 = 504 clamps to 127; -128 - 127 = -255 clamps to -128
    run_sample(8'sd0, -8'sd128, 1'b0, lat, busy);
    tests_run++; if (y_hat !== 8'sd127) begin tests_failed++; $display("FAIL sat_y_hat: got %0d want 127", y_hat); end
    tests_run++; if (err !== -8'sd128) begin tests_failed++; $display("FAIL sat_err: got %0d want -128", err); end
    ack();
  endtask

  task automatic test_freeze_backpressure();
    int lat, busy, hold_bad, ready_bad;
    load_coef(8'sd32, 8'sd0);
    run_sample(8'sd64, 8'sd0, 1'b0, lat, busy);
    ack();
    run_sample(8'sd0, 8'sd40, 1'b0, lat, busy);
    tests_run++; if (lat !== 3) begin tests_failed++; $display("FAIL freeze_latency: got %0d want 3", lat); end
    tests_run++; if (y_hat !== 8'sd32 || err !== 8'sd8) begin tests_failed++; $display("FAIL freeze_result: got y_hat=%0d err=%0d want 32 8", y_hat, err); end
    tests_run++; if (a_hat !== 8'sd32 || b_hat !== 8'sd0) begin tests_failed++; $display("FAIL freeze_coef: got a=%0d b=%0d want 32 0", a_hat, b_hat); end
    // Hold off the consumer while wiggling every input that must be ignored.
    hold_bad = 0; ready_bad = 0;
    in_valid = 1'b1; x_in = 8'sd5; y_in = 8'sd5; adapt_en = 1'b1;
    coef_load = 1'b1; a_init = -8'sd7; b_init = -8'sd7;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_valid !== 1'b1 || y_hat !== 8'sd32 || err !== 8'sd8 || a_hat !== 8'sd32 || b_hat !== 8'sd0) hold_bad++;
      if (in_ready !== 1'b0) ready_bad++;
    end
    in_valid = 1'b0; coef_load = 1'b0;
    tests_run++; if (hold_bad !== 0) begin tests_failed++; $display("FAIL bp_hold: %0d cycles changed want 0", hold_bad); end
    tests_run++; if (ready_bad !== 0) begin tests_failed++; $display("FAIL bp_in_ready: %0d cycles high want 0", ready_bad); end
    ack();
    tests_run++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin tests_failed++; $display("FAIL bp_release: got out_valid=%b in_ready=%b want 0 1", out_valid, in_ready); end
    tests_run++; if (a_hat !== 8'sd32 || b_hat !== 8'sd0) begin tests_failed++; $display("FAIL bp_dropped_load: got a=%0d b=%0d want 32 0", a_hat, b_hat); end
  endtask

  task automatic test_priority();
    int stray;
    coef_load = 1'b1; a_init = 8'sd20; b_init = -8'sd10;
    in_valid = 1'b1; x_in = 8'sd1; y_in = 8'sd1; adapt_en = 1'b0;
    #1;
    tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL prio_in_ready: got %b want 0", in_ready); end
    tick();
    coef_load = 1'b0; in_valid = 1'b0;
    tests_run++; if (a_hat !== 8'sd20 || b_hat !== -8'sd10) begin tests_failed++; $display("FAIL prio_load: got a=%0d b=%0d want 20 -10", a_hat, b_hat); end
    stray = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid !== 1'b0 || in_ready !== 1'b1) stray++;
    end
    tests_run++; if (stray !== 0) begin tests_failed++; $display("FAIL prio_no_accept: %0d busy cycles want 0", stray); end
  endtask

  task automatic test_reset_mid_step();
    int lat, busy;
    run_sample(8'sd50, 8'sd30, 1'b0, lat, busy);
    ack();
    x_in = 8'sd10; y_in = 8'sd10; adapt_en = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tests_run++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin tests_failed++; $display("FAIL mid_rst_ctrl: got out_valid=%b in_ready=%b want 0 1", out_valid, in_ready); end
    tests_run++; if ({y_hat, err, a_hat, b_hat} !== 32'h0) begin tests_failed++; $display("FAIL mid_rst_regs: got %0d %0d %0d %0d want 0 0 0 0", y_hat, err, a_hat, b_hat); end
    // Cleared delay line: nonzero coefficients must still predict 0.
    load_coef(8'sd32, 8'sd16);
    run_sample(8'sd0, 8'sd0, 1'b0, lat, busy);
    tests_run++; if (y_hat !== 8'sd0 || err !== 8'sd0) begin tests_failed++; $display("FAIL mid_rst_delay: got y_hat=%0d err=%0d want 0 0", y_hat, err); end
    ack();
  endtask

  task automatic test_back_to_back();
    int acc;
    out_ready = 1'b1; in_valid = 1'b1; x_in = 8'sd0; y_in = 8'sd0; adapt_en = 1'b0;
    acc = 0;
    for (int i = 0; i < 20; i++) begin
      if (in_ready && in_valid) acc++;
      tick();
    end
    tests_run++; if (acc !== 4) begin tests_failed++; $display("FAIL b2b_noadapt: got %0d accepts want 4", acc); end
    adapt_en = 1'b1;
    acc = 0;
    for (int i = 0; i < 21; i++) begin
      if (in_ready && in_valid) acc++;
      tick();
    end
    tests_run++; if (acc !== 3) begin tests_failed++; $display("FAIL b2b_adapt: got %0d accepts want 3", acc); end
    in_valid = 1'b0; out_ready = 1'b0; adapt_en = 1'b0;
    tick();
  endtask

  task automatic test_convergence();
    int lat, busy, bad, xp, yp, xn, yn, da, db;
    logic signed [7:0] xe, ye;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    load_coef(8'sd32, 8'sd16);
    xp = 0; yp = 0; bad = 0;
    for (int n = 0; n < 400; n++) begin
      // Plant: y[n] = sat8(floor(32*x[n-1]/64) + floor(16*y[n-1]/64))
      yn = ((32 * xp) >>> 6) + ((16 * yp) >>> 6);
      if (yn > 127) yn = 127;
      if (yn < -128) yn = -128;
      xn = int'($urandom_range(127, 0)) - 64;
      xe = 8'(xn); ye = 8'(yn);
      run_sample(xe, ye, 1'b1, lat, busy);
      if (y_hat !== ye || err !== 8'sd0 || lat !== 5) bad++;
      ack();
      xp = xn; yp = yn;
    end
    tests_run++; if (bad !== 0) begin tests_failed++; $display("FAIL conv_track: %0d steps off the plant want 0", bad); end
    da = int'(a_hat) - 32;
    db = int'(b_hat) - 16;
    tests_run++; if (da > 2 || da < -2) begin tests_failed++; $display("FAIL conv_a_hat: got %0d want 32+-2", a_hat); end
    tests_run++; if (db > 2 || db < -2) begin tests_failed++; $display("FAIL conv_b_hat: got %0d want 16+-2", b_hat); end
  endtask

  initial begin
    tests_run = 0; tests_failed = 0;
    reset = 1'b1; coef_load = 1'b0; a_init = 8'sd0; b_init = 8'sd0;
    adapt_en = 1'b0; in_valid = 1'b0; x_in = 8'sd0; y_in = 8'sd0; out_ready = 1'b0;
    test_reset();
    test_basic_update();
    test_saturation();
    test_freeze_backpressure();
    test_priority();
    test_reset_mid_step();
    test_back_to_back();
    test_convergence();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
